// File: rtl/seq_detector_pkg.sv
// seq_detector_pkg
// Shared definitions for the pattern detector: FSM state encoding and the
// default parameter values used by seq_detector and its testbench.
package seq_detector_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int DEF_W     = 2;
    localparam int DEF_LEN   = 4;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/seq_hist_shift.sv
// seq_hist_shift
// LEN-symbol history register. New symbols enter at the top (newest) slot and
// the oldest symbol falls out of bits [W-1:0].
// Ports:
//   clk      - clock
//   rst_n    - asynchronous active-low reset (already synchronised by the parent)
//   clr      - synchronous clear of the whole history
//   shift    - shift sym into the newest slot
//   sym      - incoming symbol
//   hist     - registered history
//   hist_nxt - history as it will look after shifting sym in (for same-cycle compare)
module seq_hist_shift #(
    parameter int W   = 2,
    parameter int LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift,
    input  logic [W-1:0]     sym,
    output logic [LEN*W-1:0] hist,
    output logic [LEN*W-1:0] hist_nxt
);

    assign hist_nxt = {sym, hist[LEN*W-1:W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
        end else if (clr) begin
            hist <= '0;
        end else if (shift) begin
            hist <= hist_nxt;
        end
    end

endmodule

// File: rtl/seq_detector.sv
// seq_detector
// Streaming pattern detector: compares the last LEN accepted symbols against a
// loadable pattern and emits a registered one-cycle pulse on each match.
// Optional feature macro: SEQ_DETECTOR_CNT_EN enables the saturating match
// counter; without it match_cnt is tied to 0 and cnt_clr is ignored.
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous active-low reset (deassertion synchronised here)
//   en        - detector enable, low forces IDLE
//   in_valid  - in_sym carries a symbol
//   in_sym    - input symbol
//   pat_load  - capture pat_in (wins over a same-cycle symbol)
//   pat_in    - pattern, bits [W-1:0] oldest symbol
//   overlap   - 1 = overlapping matches, 0 = restart history after a match
//   cnt_clr   - synchronous clear of match_cnt
//   q         - one-cycle match pulse, one cycle after the completing symbol
//   match_cnt - saturating match count
//   state     - current FSM state
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | disabled or no pattern loaded; symbols ignored
// FILL  | collecting symbols, fewer than LEN in history
// RUN   | history full, every symbol can complete a match
module seq_detector
    import seq_detector_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int LEN   = DEF_LEN,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in_valid,
    input  logic [W-1:0]     in_sym,
    input  logic             pat_load,
    input  logic [LEN*W-1:0] pat_in,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             q,
    output logic [CNT_W-1:0] match_cnt,
    output logic [1:0]       state
);

    localparam int FW = $clog2(LEN + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(LEN);

    logic [1:0]       rst_sync;
    logic             rst_n;
    state_t           st;
    state_t           st_nxt;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_nxt;
    logic [FW-1:0]    fill_inc;
    logic             loaded;
    logic [LEN*W-1:0] pattern;
    logic [LEN*W-1:0] hist;
    logic [LEN*W-1:0] hist_shifted;
    logic             accept;
    logic             match;
    logic             q_r;

    // Assert immediately, release two clk edges after reset goes high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    seq_hist_shift #(
        .W   (W),
        .LEN (LEN)
    ) u_hist (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (pat_load),
        .shift    (accept),
        .sym      (in_sym),
        .hist     (hist),
        .hist_nxt (hist_shifted)
    );

    assign fill_inc = (fill == FILL_MAX) ? FILL_MAX : fill + FW'(1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    // Next-state and fill logic
    always_comb begin
        st_nxt   = st;
        fill_nxt = fill;
        if (!en) begin
            st_nxt   = IDLE;
            fill_nxt = '0;
        end else if (pat_load) begin
            st_nxt   = FILL;
            fill_nxt = '0;
        end else begin
            if (accept) begin
                fill_nxt = (match && !overlap) ? '0 : fill_inc;
            end
            case (st)
                IDLE:    st_nxt = loaded ? FILL : IDLE;
                FILL:    st_nxt = (fill_nxt == FILL_MAX) ? RUN : FILL;
                RUN:     st_nxt = (fill_nxt == '0) ? FILL : RUN;
                default: st_nxt = IDLE;
            endcase
        end
    end

    // Output / datapath decode
    always_comb begin
        accept = en && in_valid && !pat_load && ((st == FILL) || (st == RUN));
        match  = accept && (fill_inc == FILL_MAX) && (hist_shifted == pattern);
        state  = st;
        q      = q_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill    <= '0;
            pattern <= '0;
            loaded  <= 1'b0;
            q_r     <= 1'b0;
        end else begin
            fill <= fill_nxt;
            q_r  <= match;
            if (pat_load) begin
                pattern <= pat_in;
                loaded  <= 1'b1;
            end
        end
    end

`ifdef SEQ_DETECTOR_CNT_EN
    logic [CNT_W-1:0] cnt;

    // A clear coinciding with a match still counts that match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= match ? CNT_W'(1) : '0;
        end else if (match && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign match_cnt = cnt;
`else
    logic cnt_clr_unused;

    assign cnt_clr_unused = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// tb_seq_detector
// Scoreboard bench for seq_detector at default parameters (W=2, LEN=4, CNT_W=8).
// Expected q values are queued as each symbol is driven and checked when the
// registered pulse appears. Counter expectations follow SEQ_DETECTOR_CNT_EN.
module tb_seq_detector;
    import seq_detector_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_sym = '0;
    logic       pat_load = 1'b0;
    logic [7:0] pat_in = '0;
    logic       overlap = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       q;
    logic [7:0] match_cnt;
    logic [1:0] state;

    int   errors = 0;
    int   checks = 0;
    int   pulses = 0;
    logic exp_q[$];

    localparam logic [7:0] PAT_0123 = 8'hE4;  // {3,2,1,0}, oldest in low bits
    localparam logic [7:0] PAT_1111 = 8'h55;

    seq_detector dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (in_valid),
        .in_sym    (in_sym),
        .pat_load  (pat_load),
        .pat_in    (pat_in),
        .overlap   (overlap),
        .cnt_clr   (cnt_clr),
        .q         (q),
        .match_cnt (match_cnt),
        .state     (state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_cnt(input int n);
`ifdef SEQ_DETECTOR_CNT_EN
        return (n > 255) ? 8'd255 : 8'(n);
`else
        return 8'd0;
`endif
    endfunction

    task automatic step(input logic v, input logic [1:0] s, input logic ld, input logic e);
        logic want;
        @(negedge clk);
        in_valid = v;
        in_sym   = s;
        pat_load = ld;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        checks++;
        if (q !== want) begin
            errors++;
            $display("FAIL q: got %b want %b (sym %0d valid %b load %b)", q, want, s, v, ld);
        end
        if (q === 1'b1) pulses++;
        in_valid = 1'b0;
        pat_load = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    task automatic check_state(input string name, input logic [1:0] want);
        checks++;
        if (state !== want) begin
            errors++;
            $display("FAIL %s state: got %0d want %0d", name, state, want);
        end
    endtask

    task automatic check_cnt(input string name, input logic [7:0] want);
        checks++;
        if (match_cnt !== want) begin
            errors++;
            $display("FAIL %s match_cnt: got %0d want %0d", name, match_cnt, want);
        end
    endtask

    task automatic do_reset();
        en = 1'b0;
        in_valid = 1'b0;
        pat_load = 1'b0;
        cnt_clr = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] p);
        pat_in = p;
        step(1'b0, 2'd0, 1'b1, 1'b0);
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1;
        step(1'b0, 2'd0, 1'b0, 1'b0);
        check_cnt("clear", 8'd0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        check_state("reset_held", 2'(IDLE));
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL reset_q: got %b want 0", q);
        end
        check_cnt("reset_held", 8'd0);
        do_reset();
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_state("no_pattern_idle", 2'(IDLE));
    endtask

    task automatic test_basic();
        logic [1:0] syms[4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic       exps[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        en = 1'b1;
        overlap = 1'b0;
        load(PAT_0123);
        check_state("basic_load", 2'(FILL));
        clear_cnt();
        for (int i = 0; i < 4; i++) step(1'b1, syms[i], 1'b0, exps[i]);
        check_cnt("basic", exp_cnt(1));
        check_state("basic_after_match", 2'(FILL));
        step(1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_overlap();
        en = 1'b1;
        overlap = 1'b1;
        load(PAT_1111);
        clear_cnt();
        pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 6) cnt_clr = 1'b1;
            step(1'b1, 2'd1, 1'b0, (i >= 4));
            if (i == 6) check_cnt("clr_with_match", exp_cnt(1));
        end
        checks++;
        if (pulses != 5) begin
            errors++;
            $display("FAIL overlap_pulses: got %0d want 5", pulses);
        end
        check_cnt("overlap_cnt", exp_cnt(3));
        check_state("overlap_run", 2'(RUN));

        overlap = 1'b0;
        load(PAT_1111);
        pulses = 0;
        for (int i = 1; i <= 8; i++) step(1'b1, 2'd1, 1'b0, (i == 4) || (i == 8));
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL nonoverlap_pulses: got %0d want 2", pulses);
        end
    endtask

    task automatic test_overlap_switch();
        logic exps[10] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
        en = 1'b1;
        overlap = 1'b1;
        load(PAT_1111);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) overlap = 1'b0;
            step(1'b1, 2'd1, 1'b0, exps[i]);
        end
    endtask

    task automatic test_gap();
        en = 1'b1;
        overlap = 1'b0;
        load(PAT_0123);
        clear_cnt();
        step(1'b1, 2'd0, 1'b0, 1'b0);
        step(1'b1, 2'd1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'd3, 1'b0, 1'b0);
            check_state("gap_hold", 2'(FILL));
        end
        step(1'b1, 2'd2, 1'b0, 1'b0);
        step(1'b1, 2'd3, 1'b0, 1'b1);
        check_cnt("gap", exp_cnt(1));
    endtask

    task automatic test_load_priority();
        logic [1:0] syms[5] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        logic       exps[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        en = 1'b1;
        overlap = 1'b0;
        load(PAT_0123);
        step(1'b1, 2'd0, 1'b0, 1'b0);
        step(1'b1, 2'd1, 1'b0, 1'b0);
        step(1'b1, 2'd2, 1'b0, 1'b0);
        pat_in = PAT_0123;
        step(1'b1, 2'd3, 1'b1, 1'b0);
        check_state("load_priority", 2'(FILL));
        step(1'b0, 2'd0, 1'b0, 1'b0);
        // fill restarted: a lone 3 cannot match, a fresh 0,1,2,3 run does
        for (int i = 0; i < 5; i++) step(1'b1, syms[i], 1'b0, exps[i]);
    endtask

    task automatic test_reset_mid();
        en = 1'b1;
        overlap = 1'b0;
        load(PAT_0123);
        step(1'b1, 2'd0, 1'b0, 1'b0);
        step(1'b1, 2'd1, 1'b0, 1'b0);
        step(1'b1, 2'd2, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_sym = 2'd3;
        #2;
        reset = 1'b0;
        #1;
        check_state("reset_async", 2'(IDLE));
        @(posedge clk);
        #1;
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_q: got %b want 0", q);
        end
        check_cnt("reset_mid", 8'd0);
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_state("rearm_needed", 2'(IDLE));
        load(PAT_0123);
        check_state("rearmed", 2'(FILL));
    endtask

    task automatic test_saturate();
        en = 1'b1;
        overlap = 1'b1;
        load(PAT_1111);
        clear_cnt();
        for (int i = 1; i <= 300; i++) begin
            step(1'b1, 2'd1, 1'b0, (i >= 4));
            if ((i % 50 == 0) || (i >= 257 && i <= 259)) check_cnt("saturate_run", exp_cnt((i >= 4) ? i - 3 : 0));
        end
        check_cnt("saturate_final", exp_cnt(297));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_overlap_switch();
        test_gap();
        test_load_priority();
        test_reset_mid();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
